// File: rtl/magic_nmi_ctl.sv
// magic_nmi_ctl: magic-mode / NMI controller for the Sizif core.
// Up to N_SRC trigger sources raise an NMI on a frame edge and the first source
// set is latched as the cause. The magic ROM is mapped once the CPU fetches the
// NMI vector. If the CPU never fetches it, the request is dropped after
// TIMEOUT_FRAMES frames. A small config register bank is reachable through an IO
// port, but only while the magic ROM is mapped.
module magic_nmi_ctl #(
  parameter int                   N_SRC          = 4,
  parameter int                   N_REGS         = 16,
  parameter logic [7:0]           CFG_PORT       = 8'hFF,
  parameter logic [15:0]          NMI_VEC        = 16'h0066,
  parameter logic [15:0]          EXIT_ADDR      = 16'hF000,
  parameter logic [15:0]          REENTER_ADDR   = 16'hF008,
  parameter int                   TIMEOUT_FRAMES = 4,
  parameter bit                   MAGIC_ON_START = 1'b1,
  parameter logic [N_REGS*8-1:0]  REG_RESET      = '0
) (
  input  logic                   clk28,
  input  logic                   rst_n,
  input  logic [15:0]            bus_a,
  input  logic [7:0]             bus_d,
  input  logic                   bus_rd,
  input  logic                   bus_wr,
  input  logic                   bus_memreq,
  input  logic                   bus_ioreq,
  input  logic                   bus_m1,
  input  logic                   bus_memreq_rise,
  input  logic                   n_int,
  input  logic                   n_int_next,
  input  logic [N_SRC-1:0]       trig,
  output logic [7:0]             d_out,
  output logic                   d_out_active,
  output logic                   n_nmi,
  output logic                   magic_mode,
  output logic                   magic_map,
  output logic [N_REGS*8-1:0]    cfg,
  output logic [N_SRC-1:0]       cause
);

  localparam int TW = $clog2(TIMEOUT_FRAMES + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PEND   = 3'd1,
    MAPPED = 3'd2,
    UNMAP  = 3'd3,
    REMAP  = 3'd4
  } state_t;

  state_t                 state_q;
  logic                   nNmi_q;
  logic                   magicMode_q;
  logic                   magicMap_q;
  logic [N_SRC-1:0]       cause_q;
  logic                   timeout_q;
  logic [TW-1:0]          tcnt_q;
  logic                   exitPending_q;
  logic                   remap_q;

  logic [N_REGS*8-1:8]    regs_q;
  logic [7:0]             dOut_q;
  logic [7:0]             dOut_d;
  logic                   dOutActive_q;

  logic                   fe;
  logic                   ack;
  logic                   memread;
  logic                   cs;
  logic                   cfgWr;
  logic                   cfgRd;
  logic [7:0]             idx;
  logic [7:0]             status;
  logic [7:0]             rdSel;

  assign fe      = n_int & ~n_int_next;
  assign ack     = bus_m1 & bus_memreq_rise & (bus_a == NMI_VEC);
  assign memread = bus_memreq & bus_rd;
  assign cs      = magicMap_q & bus_ioreq & (bus_a[7:0] == CFG_PORT);
  assign cfgWr   = cs & bus_wr;
  assign cfgRd   = cs & bus_rd;
  assign idx     = bus_a[15:8];

  // Session FSM: NMI request, acknowledge or timeout, ROM map/unmap and the cause/timeout flags.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= MAGIC_ON_START ? MAPPED : IDLE;
      magicMode_q   <= MAGIC_ON_START;
      magicMap_q    <= MAGIC_ON_START;
      nNmi_q        <= 1'b1;
      cause_q       <= '0;
      timeout_q     <= 1'b0;
      tcnt_q        <= '0;
      exitPending_q <= 1'b0;
      remap_q       <= 1'b0;
    end else begin
      if (cfgWr && (idx == 8'd0)) begin
        cause_q <= cause_q & ~bus_d[N_SRC-1:0];
        if (bus_d[7]) begin
          timeout_q <= 1'b0;
        end
      end
      case (state_q)
        IDLE: begin
          if (fe && (|trig)) begin
            nNmi_q      <= 1'b0;
            magicMode_q <= 1'b1;
            cause_q     <= trig;
            tcnt_q      <= '0;
            state_q     <= PEND;
          end
        end
        PEND: begin
          if (ack) begin
            nNmi_q     <= 1'b1;
            magicMap_q <= 1'b1;
            state_q    <= MAPPED;
          end else if (fe) begin
            if (tcnt_q == TW'(TIMEOUT_FRAMES - 1)) begin
              nNmi_q      <= 1'b1;
              magicMode_q <= 1'b0;
              timeout_q   <= 1'b1;
              state_q     <= IDLE;
            end else begin
              tcnt_q <= tcnt_q + TW'(1);
            end
          end
        end
        MAPPED: begin
          if (memread && (bus_a == EXIT_ADDR)) begin
            magicMode_q   <= 1'b0;
            exitPending_q <= 1'b1;
            state_q       <= UNMAP;
          end else if (memread && (bus_a == REENTER_ADDR)) begin
            remap_q <= 1'b1;
            state_q <= UNMAP;
          end
        end
        UNMAP: begin
          if (!bus_memreq) begin
            magicMap_q    <= 1'b0;
            exitPending_q <= 1'b0;
            state_q       <= (remap_q && !exitPending_q) ? REMAP : IDLE;
          end
        end
        REMAP: begin
          if (bus_m1 && bus_memreq_rise) begin
            magicMap_q <= 1'b1;
            remap_q    <= 1'b0;
            state_q    <= MAPPED;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Status image and read-data selection for the currently addressed register.
  always_comb begin
    status             = '0;
    status[N_SRC-1:0]  = cause_q;
    status[7]          = timeout_q;
    rdSel              = 8'hFF;
    if (idx == 8'd0) begin
      rdSel = status;
    end else begin
      for (int i = 1; i < N_REGS; i++) begin
        if (idx == 8'(i)) begin
          rdSel = regs_q[8*i +: 8];
        end
      end
    end
    dOut_d = cfgRd ? rdSel : 8'h00;
  end

  // Config register writes and the registered read port.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      regs_q       <= REG_RESET[N_REGS*8-1:8];
      dOut_q       <= 8'h00;
      dOutActive_q <= 1'b0;
    end else begin
      if (cfgWr) begin
        for (int i = 1; i < N_REGS; i++) begin
          if (idx == 8'(i)) begin
            regs_q[8*i +: 8] <= bus_d;
          end
        end
      end
      dOutActive_q <= cfgRd;
      dOut_q       <= dOut_d;
    end
  end

  assign d_out        = dOut_q;
  assign d_out_active = dOutActive_q;
  assign n_nmi        = nNmi_q;
  assign magic_mode   = magicMode_q;
  assign magic_map    = magicMap_q;
  assign cause        = cause_q;
  assign cfg          = {regs_q, status};

endmodule

// File: tb/tb_magic_nmi_ctl.sv
// tb_magic_nmi_ctl: directed bench for magic_nmi_ctl, read data checked via an expected-value queue.
module tb_magic_nmi_ctl;

  localparam logic [127:0] REG_RST = 128'h0F0E0D0C0B0A090807060504030201AA;
  localparam logic [127:0] CFG_RST = 128'h0F0E0D0C0B0A09080706050403020100;

  logic         clk28;
  logic         rst_n;
  logic [15:0]  bus_a;
  logic [7:0]   bus_d;
  logic         bus_rd, bus_wr, bus_memreq, bus_ioreq, bus_m1, bus_memreq_rise;
  logic         n_int, n_int_next;
  logic [3:0]   trig;
  logic [7:0]   d_out;
  logic         d_out_active, n_nmi, magic_mode, magic_map;
  logic [127:0] cfg;
  logic [3:0]   cause;

  int tests = 0;
  int fails = 0;
  logic [7:0] expQ[$];

  magic_nmi_ctl #(
    .N_SRC(4), .N_REGS(16), .MAGIC_ON_START(1'b1), .REG_RESET(REG_RST)
  ) dut (
    .clk28(clk28), .rst_n(rst_n), .bus_a(bus_a), .bus_d(bus_d),
    .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_memreq(bus_memreq), .bus_ioreq(bus_ioreq),
    .bus_m1(bus_m1), .bus_memreq_rise(bus_memreq_rise),
    .n_int(n_int), .n_int_next(n_int_next), .trig(trig),
    .d_out(d_out), .d_out_active(d_out_active), .n_nmi(n_nmi),
    .magic_mode(magic_mode), .magic_map(magic_map), .cfg(cfg), .cause(cause)
  );

  // 28 MHz-ish free-running clock.
  initial clk28 = 1'b0;
  always #5 clk28 = ~clk28;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk28);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] a, input logic [7:0] d,
                               input logic rd, input logic wr, input logic mreq,
                               input logic ioreq, input logic m1, input logic rise);
    bus_a = a; bus_d = d; bus_rd = rd; bus_wr = wr;
    bus_memreq = mreq; bus_ioreq = ioreq; bus_m1 = m1; bus_memreq_rise = rise;
  endtask

  task automatic releaseBus();
    applyStimulus(16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ioWrite(input logic [7:0] idx, input logic [7:0] data);
    applyStimulus({idx, 8'hFF}, data, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1);
    releaseBus();
  endtask

  task automatic ioRead(input string tag, input logic [7:0] idx, input logic [7:0] exp);
    logic [7:0] want;
    applyStimulus({idx, 8'hFF}, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    expQ.push_back(exp);
    step(1);
    releaseBus();
    for (int k = 0; k < 4; k++) begin
      if (d_out_active) break;
      step(1);
    end
    want = expQ.pop_front();
    checkOutput({tag, " active"}, d_out_active, 1'b1);
    checkOutput({tag, " data"}, d_out, want);
    step(1);
    checkOutput({tag, " release"}, d_out_active, 1'b0);
  endtask

  task automatic memRead(input logic [15:0] addr);
    applyStimulus(addr, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1);
  endtask

  task automatic m1Fetch(input logic [15:0] addr);
    applyStimulus(addr, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    step(1);
    releaseBus();
  endtask

  task automatic frameEdge();
    n_int_next = 1'b0;
    step(1);
    n_int_next = 1'b1;
  endtask

  task automatic exitMagic();
    memRead(16'hF000);
    releaseBus();
    step(1);
  endtask

  // Directed sequence covering one full life cycle of magic sessions.
  initial begin
    rst_n = 1'b0; n_int = 1'b1; n_int_next = 1'b1; trig = 4'b0000;
    releaseBus();
    step(2);
    checkOutput("rst n_nmi", n_nmi, 1'b1);
    checkOutput("rst magic_mode", magic_mode, 1'b1);
    checkOutput("rst magic_map", magic_map, 1'b1);
    checkOutput("rst d_out_active", d_out_active, 1'b0);
    checkOutput("rst d_out", d_out, 8'h00);
    checkOutput("rst cause", cause, 4'h0);
    checkOutput("rst cfg", cfg, CFG_RST);
    rst_n = 1'b1;
    step(1);

    memRead(16'hF000);
    checkOutput("exit mode", magic_mode, 1'b0);
    checkOutput("exit map held", magic_map, 1'b1);
    releaseBus();
    step(1);
    checkOutput("exit unmap", magic_map, 1'b0);

    ioWrite(8'h05, 8'hA5);
    checkOutput("unmapped write", cfg[47:40], 8'h05);

    trig = 4'b0010;
    frameEdge();
    trig = 4'b0000;
    checkOutput("trig n_nmi", n_nmi, 1'b0);
    checkOutput("trig cause", cause, 4'b0010);
    checkOutput("trig mode", magic_mode, 1'b1);
    checkOutput("trig map", magic_map, 1'b0);

    m1Fetch(16'h0066);
    checkOutput("ack n_nmi", n_nmi, 1'b1);
    checkOutput("ack map", magic_map, 1'b1);
    ioRead("status", 8'h00, 8'h02);

    ioWrite(8'h05, 8'hA5);
    checkOutput("reg5 cfg", cfg[47:40], 8'hA5);
    ioRead("reg5", 8'h05, 8'hA5);
    ioRead("oob", 8'h20, 8'hFF);
    ioRead("reg1", 8'h01, 8'h01);

    memRead(16'hF008);
    checkOutput("reenter map held", magic_map, 1'b1);
    releaseBus();
    step(1);
    checkOutput("reenter unmap", magic_map, 1'b0);
    checkOutput("reenter mode", magic_mode, 1'b1);
    m1Fetch(16'h1234);
    checkOutput("remap map", magic_map, 1'b1);
    checkOutput("remap mode", magic_mode, 1'b1);

    ioWrite(8'h00, 8'h0F);
    ioRead("cause clear", 8'h00, 8'h00);

    exitMagic();
    checkOutput("exit2 map", magic_map, 1'b0);
    trig = 4'b0001;
    frameEdge();
    trig = 4'b0000;
    checkOutput("to n_nmi low", n_nmi, 1'b0);
    repeat (3) frameEdge();
    checkOutput("to 3 frames", n_nmi, 1'b0);
    frameEdge();
    checkOutput("to n_nmi", n_nmi, 1'b1);
    checkOutput("to mode", magic_mode, 1'b0);
    checkOutput("to status", cfg[7:0], 8'h81);

    trig = 4'b0100;
    frameEdge();
    trig = 4'b0000;
    checkOutput("retrig status", cfg[7:0], 8'h84);
    repeat (3) frameEdge();
    applyStimulus(16'h0066, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    n_int_next = 1'b0;
    step(1);
    n_int_next = 1'b1;
    releaseBus();
    checkOutput("ackwin n_nmi", n_nmi, 1'b1);
    checkOutput("ackwin map", magic_map, 1'b1);
    checkOutput("ackwin mode", magic_mode, 1'b1);
    ioRead("ackwin status", 8'h00, 8'h84);
    ioWrite(8'h00, 8'h04);
    ioRead("w1c cause", 8'h00, 8'h80);

    trig = 4'b0011;
    frameEdge();
    trig = 4'b0000;
    checkOutput("ignored n_nmi", n_nmi, 1'b1);
    checkOutput("ignored cause", cause, 4'b0000);
    ioWrite(8'h00, 8'h80);
    ioRead("w1c timeout", 8'h00, 8'h00);

    exitMagic();
    trig = 4'b0010;
    frameEdge();
    trig = 4'b0000;
    checkOutput("pend n_nmi", n_nmi, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst n_nmi", n_nmi, 1'b1);
    checkOutput("arst cause", cause, 4'h0);
    checkOutput("arst cfg", cfg, CFG_RST);
    checkOutput("arst mode", magic_mode, 1'b1);
    checkOutput("arst map", magic_map, 1'b1);
    step(1);
    rst_n = 1'b1;
    step(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
